counter_sync_ctrl: RTL and testbench

Run controller for a pair of free-running counters with a rendezvous-and-sum datapath. On `start` it latches a run configuration, then clears and steps counters `a` and `b`. Each counter pauses at its own programmed stop points. When both are paused, the block registers `w = a + b` and releases both counters. The run ends when the rendezvous happens with `b` equal to a programmed final value. It sits between a host/test sequencer and the counter/sum datapath, replacing hard-coded stop constants with configurable ones and adding a start/busy/done handshake.

---
 rtl/counter_sync_pkg.sv | 21 ++
 rtl/counter_sync_ctrl_stop_counter.sv | 66 ++++++
 rtl/counter_sync_ctrl.sv | 111 +++++++++++
 tb/tb_counter_sync_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_sync_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter_sync_pkg : shared types for the counter rendezvous controller |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package counter_sync_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

    typedef enum logic [0:0] {
        COUNT = 1'b0,
        HOLD  = 1'b1
    } cnt_state_t;

endpackage
`default_nettype wire

// File: rtl/counter_sync_ctrl_stop_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stop_counter : wrapping counter that parks on either of two stops     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module stop_counter
    import counter_sync_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic             clear_i,
    input  logic             release_i,
    input  logic [WIDTH-1:0] stop0_i,
    input  logic [WIDTH-1:0] stop1_i,
    output logic [WIDTH-1:0] value_o,
    output logic             held_o
);

    cnt_state_t       state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] value_inc;

    always_comb begin
        value_inc = value_q + 1'b1;
        value_d   = value_q;
        state_d   = state_q;
        if (clear_i) begin
            value_d = '0;
            state_d = COUNT;
        end else if (en_i) begin
            case (state_q)
                COUNT: begin
                    value_d = value_inc;
                    // Compare the incremented value so the counter parks on the stop
                    if (value_inc == stop0_i || value_inc == stop1_i) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (release_i) begin
                        state_d = COUNT;
                    end
                end
                default: state_d = COUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            value_q <= '0;
            state_q <= COUNT;
        end else begin
            value_q <= value_d;
            state_q <= state_d;
        end
    end

    assign value_o = value_q;
    assign held_o  = (state_q == HOLD);

endmodule
`default_nettype wire

// File: rtl/counter_sync_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter_sync_ctrl : start/busy/done run control and rendezvous sum    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module counter_sync_ctrl
    import counter_sync_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_stop0,
    input  logic [WIDTH-1:0] a_stop1,
    input  logic [WIDTH-1:0] b_stop0,
    input  logic [WIDTH-1:0] b_stop1,
    input  logic [WIDTH-1:0] b_last,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] w,
    output logic             w_valid,
    output logic             busy,
    output logic             done
);

    ctrl_state_t      state_q, state_d;
    logic [WIDTH-1:0] a_stop0_q, a_stop1_q, b_stop0_q, b_stop1_q, b_last_q;
    logic [WIDTH-1:0] w_q;
    logic             w_valid_q, done_q;
    logic [WIDTH-1:0] a_val, b_val;
    logic             a_held, b_held;
    logic             run, start_acc, rendezvous, finish, rel;

    assign run        = (state_q == RUN);
    assign start_acc  = (state_q == IDLE) && start;
    assign rendezvous = run && a_held && b_held;
    assign finish     = rendezvous && (b_val == b_last_q);
    // The final rendezvous leaves both counters parked for inspection
    assign rel        = rendezvous && !finish;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            a_stop0_q <= '0;
            a_stop1_q <= '0;
            b_stop0_q <= '0;
            b_stop1_q <= '0;
            b_last_q  <= '0;
            w_q       <= '0;
            w_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_valid_q <= rendezvous;
            done_q    <= finish;
            if (rendezvous) begin
                w_q <= a_val + b_val;
            end
            if (start_acc) begin
                a_stop0_q <= a_stop0;
                a_stop1_q <= a_stop1;
                b_stop0_q <= b_stop0;
                b_stop1_q <= b_stop1;
                b_last_q  <= b_last;
            end
        end
    end

    stop_counter #(.WIDTH(WIDTH)) u_cnt_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .en_i      (run),
        .clear_i   (start_acc),
        .release_i (rel),
        .stop0_i   (a_stop0_q),
        .stop1_i   (a_stop1_q),
        .value_o   (a_val),
        .held_o    (a_held)
    );

    stop_counter #(.WIDTH(WIDTH)) u_cnt_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .en_i      (run),
        .clear_i   (start_acc),
        .release_i (rel),
        .stop0_i   (b_stop0_q),
        .stop1_i   (b_stop1_q),
        .value_o   (b_val),
        .held_o    (b_held)
    );

    assign a       = a_val;
    assign b       = b_val;
    assign w       = w_q;
    assign w_valid = w_valid_q;
    assign busy    = run;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_sync_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_counter_sync_ctrl : scoreboard bench for counter_sync_ctrl         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_counter_sync_ctrl;

    localparam int M = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a_stop0 = '0, a_stop1 = '0, b_stop0 = '0, b_stop1 = '0, b_last = '0;
    logic [3:0] a, b, w;
    logic       w_valid, busy, done;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        int a; int b; bit busy; bit wv; bit done; bit chk_w; int w;
    } edge_t;
    typedef struct { int e; int w; bit done; } rdv_t;
    typedef struct { int as0; int as1; int bs0; int bs1; int bl; } cfg_t;

    edge_t exp_tab[int];
    rdv_t  rdv_q[$];

    counter_sync_ctrl #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a_stop0 (a_stop0),
        .a_stop1 (a_stop1),
        .b_stop0 (b_stop0),
        .b_stop1 (b_stop1),
        .b_last  (b_last),
        .a       (a),
        .b       (b),
        .w       (w),
        .w_valid (w_valid),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic put(input int e, input int va, input int vb, input bit bz, input bit wv, input bit dn);
        edge_t x;
        x.a = va; x.b = vb; x.busy = bz; x.wv = wv; x.done = dn; x.chk_w = 1'b0; x.w = 0;
        exp_tab[e] = x;
    endtask

    // Cycles from value x until the counter lands on a stop (stop 0 only via wrap)
    function automatic int steps_to_stop(input int x, input int s0, input int s1);
        for (int k = 1; k <= M; k++) begin
            if (((x + k) % M) == s0 || ((x + k) % M) == s1) return k;
        end
        return M;
    endfunction

    // Segment model: each counter walks to its next stop; the rendezvous edge
    // follows the slower one by one cycle and becomes the base of the next segment.
    task automatic plan(input cfg_t c, input int e0, input int limit, output int last);
        int xa, xb, base, ka, kb, m, e, va, vb;
        bit fin;
        rdv_t r;
        xa = 0; xb = 0; base = e0; fin = 1'b0;
        put(e0, 0, 0, 1'b1, 1'b0, 1'b0);
        while (!fin) begin
            ka = steps_to_stop(xa, c.as0, c.as1);
            kb = steps_to_stop(xb, c.bs0, c.bs1);
            m  = (ka > kb) ? ka : kb;
            for (int k = 1; k <= m + 1; k++) begin
                e = base + k;
                if (e > e0 + limit) begin
                    last = e0 + limit;
                    return;
                end
                va = (xa + ((k < ka) ? k : ka)) % M;
                vb = (xb + ((k < kb) ? k : kb)) % M;
                if (k <= m) begin
                    put(e, va, vb, 1'b1, 1'b0, 1'b0);
                end else begin
                    fin = (vb == c.bl);
                    put(e, va, vb, !fin, 1'b1, fin);
                    r.e = e; r.w = (va + vb) % M; r.done = fin;
                    rdv_q.push_back(r);
                end
            end
            xa = (xa + ka) % M;
            xb = (xb + kb) % M;
            base = base + m + 1;
        end
        put(base + 1, xa, xb, 1'b0, 1'b0, 1'b0);
        put(base + 2, xa, xb, 1'b0, 1'b0, 1'b0);
        last = base + 2;
    endtask

    // Called at a negedge; returns at the negedge of the last planned edge
    task automatic do_run(input cfg_t c, input int limit, input int ign_off);
        int e0, last;
        e0 = cyc + 1;
        a_stop0 = 4'(c.as0); a_stop1 = 4'(c.as1);
        b_stop0 = 4'(c.bs0); b_stop1 = 4'(c.bs1); b_last = 4'(c.bl);
        start = 1'b1;
        plan(c, e0, limit, last);
        @(negedge clk);
        start = 1'b0;
        while (cyc < last) begin
            if (ign_off > 0 && cyc == e0 + ign_off - 1) begin
                start   = 1'b1;
                a_stop0 = 4'(c.as0 + 5); a_stop1 = 4'(c.as1 + 7);
                b_stop0 = 4'(c.bs0 + 3); b_stop1 = 4'(c.bs1 + 1);
                b_last  = 4'(c.bl + 2);
            end
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic do_reset();
        int e;
        e = cyc + 1;
        reset_n = 1'b0;
        put(e, 0, 0, 1'b0, 1'b0, 1'b0);
        exp_tab[e].chk_w = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        edge_t ex;
        rdv_t  r;
        if (exp_tab.exists(cyc)) begin
            ex = exp_tab[cyc];
            check("a", a, ex.a);
            check("b", b, ex.b);
            check("busy", busy, ex.busy);
            check("w_valid", w_valid, ex.wv);
            check("done", done, ex.done);
            if (ex.chk_w) check("w_reset", w, ex.w);
            exp_tab.delete(cyc);
        end
        if (w_valid === 1'b1) begin
            if (rdv_q.size() == 0) begin
                check("w_valid_unplanned", w_valid, 0);
            end else begin
                r = rdv_q.pop_front();
                check("rdv_edge", cyc, r.e);
                check("w", w, r.w);
                check("done_with_w", done, r.done);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        cfg_t ref_cfg, c;
        ref_cfg = '{as0: 2, as1: 4, bs0: 3, bs1: 6, bl: 6};
        put(1, 0, 0, 1'b0, 1'b0, 1'b0); exp_tab[1].chk_w = 1'b1;
        put(2, 0, 0, 1'b0, 1'b0, 1'b0); exp_tab[2].chk_w = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        do_run(ref_cfg, 1000, 0);
        do_run(ref_cfg, 1000, 3);
        c = '{as0: 3, as1: 9, bs0: 3, bs1: 7, bl: 7};
        do_run(c, 1000, 0);
        c = '{as0: 12, as1: 13, bs0: 9, bs1: 10, bl: 9};
        do_run(c, 1000, 0);

        do_run(ref_cfg, 2, 0);
        do_reset();
        do_run(ref_cfg, 1000, 0);

        for (int i = 0; i < 8; i++) begin
            c.as0 = $urandom_range(0, 15); c.as1 = $urandom_range(0, 15);
            c.bs0 = $urandom_range(0, 15); c.bs1 = $urandom_range(0, 15);
            c.bl  = ($urandom_range(0, 1) == 1) ? c.bs0 : c.bs1;
            do_run(c, 1000, 0);
        end

        c.as0 = $urandom_range(1, 15); c.as1 = $urandom_range(0, 15);
        c.bs0 = 3; c.bs1 = 6; c.bl = 15;
        do_run(c, 70, 0);
        do_reset();

        @(negedge clk);
        check("rdv_leftover", rdv_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
